// File: rtl/simple_module_pkg.sv
// rtl/simple_module_pkg.sv - shared constants for the enabled D register
package simple_module_pkg;

  // Width used when a parent does not override WIDTH
  localparam int unsigned DEFAULT_WIDTH = 1;

endpackage : simple_module_pkg

// File: rtl/simple_module_enable_dff.sv
// rtl/simple_module_enable_dff.sv - single-bit enabled flop with async active-low reset
module enable_dff (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  input  logic rst_val,
  output logic q
);

  // Async reset loads rst_val at once; otherwise capture d on enabled rising edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : enable_dff

// File: rtl/simple_module.sv
// rtl/simple_module.sv - WIDTH-bit enabled D register built from per-bit enable_dff cells
module simple_module
  import simple_module_pkg::*;
#(
  parameter int unsigned           WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reject widths outside 1..64 while elaborating
  if ((WIDTH < 1) || (WIDTH > 64)) begin : g_bad_width
    $error("simple_module: WIDTH=%0d is outside the legal range 1..64", WIDTH);
  end

  // One flop per bit; all cells share clk, rst_n and en so every bit updates together
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    enable_dff u_dff (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .d       (d[i]),
      .rst_val (RESET_VAL[i]),
      .q       (q[i])
    );
  end

endmodule : simple_module

// File: tb/tb_simple_module.sv
// tb/tb_simple_module.sv - self-checking bench for simple_module (WIDTH=1 and WIDTH=8)
module tb_simple_module;

  logic       clk;
  logic       rst_n1, en1;
  logic [0:0] d1, q1;
  logic       rst_n8, en8;
  logic [7:0] d8, q8;

  int tests;
  int fails;

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic [7:0] exp_q;
  } vec_t;

  vec_t sweep [5];
  vec_t wvec  [2];

  logic [7:0] exp8;

  simple_module dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .en    (en1),
    .d     (d1),
    .q     (q1)
  );

  simple_module #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .en    (en8),
    .d     (d8),
    .q     (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive en1/d1 at the falling edge, then settle just past the next rising edge
  task automatic step1(input logic e, input logic dd);
    @(negedge clk);
    en1 = e;
    d1  = dd;
    @(posedge clk);
    #2;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n1 = 1'b1;
    rst_n8 = 1'b1;
    en1    = 1'b0;
    d1     = 1'b0;
    en8    = 1'b0;
    d8     = 8'h00;

    sweep[0] = '{en: 1'b0, d: 8'h00, exp_q: 8'h00};
    sweep[1] = '{en: 1'b0, d: 8'h01, exp_q: 8'h00};
    sweep[2] = '{en: 1'b1, d: 8'h01, exp_q: 8'h01};
    sweep[3] = '{en: 1'b1, d: 8'h00, exp_q: 8'h00};
    sweep[4] = '{en: 1'b0, d: 8'h00, exp_q: 8'h00};

    wvec[0] = '{en: 1'b1, d: 8'h3C, exp_q: 8'h3C};
    wvec[1] = '{en: 1'b0, d: 8'hFF, exp_q: 8'h3C};

    // Initial reset of both instances
    #1;
    rst_n1 = 1'b0;
    rst_n8 = 1'b0;
    #1;
    check("reset_w1", q1, 64'h0);
    check("reset_w8", q8, 64'hA5);
    @(negedge clk);
    rst_n1 = 1'b1;
    rst_n8 = 1'b1;

    // Reset takes effect between edges, before any clock edge
    step1(1'b1, 1'b1);
    check("preload_q1", q1, 64'h1);
    @(negedge clk);
    rst_n1 = 1'b0;
    #1;
    check("async_reset_same_step", q1, 64'h0);
    @(negedge clk);
    rst_n1 = 1'b1;
    en1    = 1'b0;
    d1     = 1'b0;

    // Enable sweep through {en,d} = 00,01,11,10,00
    for (int i = 0; i < 5; i++) begin
      step1(sweep[i].en, sweep[i].d[0]);
      check($sformatf("sweep[%0d]", i), q1, 64'(sweep[i].exp_q[0]));
    end

    // Hold: load 1, then en=0 with d toggling for 5 edges
    step1(1'b1, 1'b1);
    check("hold_load", q1, 64'h1);
    for (int i = 0; i < 5; i++) begin
      step1(1'b0, 1'(i % 2));
      check($sformatf("hold[%0d]", i), q1, 64'h1);
    end

    // Glitch: d pulses high entirely between two edges with en=1
    step1(1'b1, 1'b0);
    check("glitch_pre", q1, 64'h0);
    #1 d1 = 1'b1;
    #2 d1 = 1'b0;
    #1;
    check("glitch_between_edges", q1, 64'h0);
    @(posedge clk);
    #2;
    check("glitch_after_edge", q1, 64'h0);

    // Mid-operation reset for half a period, then recapture
    step1(1'b1, 1'b1);
    check("midrst_pre", q1, 64'h1);
    rst_n1 = 1'b0;
    #1;
    check("midrst_immediate", q1, 64'h0);
    #4;
    rst_n1 = 1'b1;
    #1;
    check("midrst_released_no_edge", q1, 64'h0);
    @(posedge clk);
    #2;
    check("midrst_recapture", q1, 64'h1);

    // Width check on the 8-bit instance
    @(negedge clk);
    rst_n8 = 1'b0;
    #1;
    check("w8_reset", q8, 64'hA5);
    @(negedge clk);
    rst_n8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      en8 = wvec[i].en;
      d8  = wvec[i].d;
      @(posedge clk);
      #2;
      check($sformatf("w8_vec[%0d]", i), q8, 64'(wvec[i].exp_q));
    end

    // Randomized run against a rule-based reference value
    exp8 = 8'h3C;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!rst_n8) begin
        rst_n8 = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        rst_n8 = 1'b0;
        exp8   = 8'hA5;
        #1;
        check("rand_async_reset", q8, 64'(exp8));
      end
      en8 = 1'($urandom);
      d8  = 8'($urandom);
      if (rst_n8 && en8) exp8 = d8;
      @(posedge clk);
      #2;
      check("rand_q", q8, 64'(exp8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_simple_module

// File: doc/simple_module.md
SIMPLE_MODULE -- requirements
Module: simple_module

Interface
REQ-001 Parameter WIDTH, default 1: data width of d and q in bits; legal range 1..64.
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits): value loaded into q on reset.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port en, input, 1 bit: load enable, active-high.
REQ-006 Port d, input, WIDTH bits: data to capture.
REQ-007 Port q, output, WIDTH bits: registered data, driven directly from a flop with no combinational path from any input.

Function
REQ-008 The block SHALL be an enabled D register: on each rising clk edge with rst_n=1 and en=1, q SHALL take the value d had just before that edge.
REQ-009 On a rising clk edge with rst_n=1 and en=0, q SHALL hold its previous value.
REQ-010 Latency from d to q SHALL be exactly one clk edge while en=1; there SHALL be no transparency (d changes between edges never reach q).
REQ-011 en and d SHALL be sampled at the same edge; an en rising together with a new d SHALL capture that new d at the following edge, not earlier.
REQ-012 Every bit of q SHALL update together; no per-bit enables or partial writes.
REQ-013 Before the first reset, q MAY be X; after any reset q SHALL be fully defined.
REQ-014 X or Z on en while rst_n=1 is illegal stimulus; the block SHALL need no recovery logic for it.

Reset
REQ-015 rst_n=0 SHALL force q to RESET_VAL immediately, without waiting for a clk edge.
REQ-016 While rst_n=0, q SHALL stay at RESET_VAL regardless of clk, en and d.
REQ-017 Reset asserted mid-operation SHALL discard held data; no state survives reset.
REQ-018 On rst_n deassertion, the first capture SHALL occur at the first rising clk edge at which rst_n=1 and en=1.
REQ-019 rst_n deassertion is assumed synchronized to clk outside the block; the block SHALL add no reset synchronizer.

Structure
REQ-020 The shared package SHALL hold only a default-width constant (value 1); RESET_VAL stays a module parameter.
REQ-021 simple_module SHALL build q from one generate loop of WIDTH instances of sub-module enable_dff (ports clk, rst_n, en, d, q, rst_val, all 1 bit).
REQ-022 enable_dff SHALL contain the only sequential process; simple_module SHALL contain only wiring and parameter checks.
REQ-023 simple_module SHALL flag an illegal WIDTH with an elaboration-time error.

Verification
REQ-024 Reset check: drive rst_n=0 between clk edges with q=1 -> q=0 within the same timestep, before the next edge (RESET_VAL=0).
REQ-025 Enable sweep: after reset, change {en,d} on each rising edge through 00,01,11,10,00 -> q stays 0 while en=0; q=1 one edge after 11 is applied; q=0 one edge after 10 is applied; q then holds 0 when en returns to 0.
REQ-026 Hold check: load q=1 (en=1, d=1), then set en=0 and toggle d every edge for 5 edges -> q stays 1.
REQ-027 Glitch check: with en=1, pulse d 0->1->0 entirely between two edges -> q stays 0.
REQ-028 Mid-operation reset: with q=1 and en=1, pull rst_n low for half a period -> q=0 at once; after release, q=1 again at the first edge with d=1, en=1.
REQ-029 Width check: WIDTH=8, RESET_VAL=8'hA5: reset -> q=8'hA5; en=1, d=8'h3C -> q=8'h3C after one edge; en=0, d=8'hFF -> q stays 8'h3C.
